multi_delay_timer: RTL and testbench
====================================

Name: multi_delay_timer

Overview:
Parametrised, multi-channel successor to the single-channel countdown delayer. It provides CHANNELS independent down-counters of WIDTH bits, each started through one shared load port. Each channel runs in one-shot or periodic (auto-reload) mode, can be retriggered or aborted, and emits a one-cycle done pulse on expiry. It sits between control FSMs and whatever they need to wait on, replacing per-FSM delayer instances.

Parameters:
- WIDTH, 12, countdown/load width in bits; legal range 2..32.
- CHANNELS, 4, number of independent timer channels; legal range 1..16.
- CH_W, max(1, clog2(CHANNELS)), channel-select width; derived, not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  load strobe; sampled each rising edge.
- load_ch  in  CH_W  target channel for start.
- load  in  WIDTH  delay in cycles for start.
- periodic  in  1  mode for start: 1 = auto-reload, 0 = one-shot.
- abort  in  CHANNELS  per-channel cancel, level-sampled each edge.
- mon_ch  in  CH_W  channel selected for the remaining readout.
- done  out  CHANNELS  per-channel one-cycle expiry pulse, registered.
- inactive  out  CHANNELS  1 = channel IDLE, registered.
- any_done  out  1  OR of done; combinational from registers.
- busy  out  1  1 when any channel is COUNTING; combinational from registers.
- remaining  out  WIDTH  countdown of channel mon_ch; 0 if mon_ch is out of range or that channel is IDLE; combinational.

Behaviour:
- Per channel, registered state: mode IDLE/COUNTING; countdown[WIDTH]; reload[WIDTH]; per[1].
- Reset (async, while rst=1):
  - all channels IDLE; countdown=0; reload=0; per=0.
  - done=0; inactive=all ones.
  - A reset mid-count discards all runs and produces no done.
- Start, on edge k with start=1, load_ch=c < CHANNELS, load=N:
  - If N≠0: countdown<=N, reload<=N, per<=periodic, mode<=COUNTING. inactive[c]=0 from edge k.
  - If N=0: treated exactly as abort of channel c.
  - If load_ch ≥ CHANNELS: start is ignored; no state change.
- Counting, each edge while COUNTING with no start or abort hitting the channel:
  - countdown>1: countdown<=countdown-1.
  - countdown==1: done[c]<=1 for exactly one cycle.
    - per=0: mode<=IDLE, countdown<=0, inactive[c]<=1 on the same edge.
    - per=1: countdown<=reload, channel stays COUNTING.
- Latency:
  - done[c] is high from edge k+N to edge k+N+1. N=1 gives done after edge k+1.
  - Periodic mode gives done at k+N, k+2N, k+3N, …
  - In one-shot mode inactive[c] is low on edges k..k+N-1 and high from edge k+N, i.e. already high during the done cycle.
- Retrigger: a start to a COUNTING channel reloads it with the new N and mode. The old run produces no done, including when the old run would have expired on the same edge (start wins over expiry).
- Abort: abort[c]=1 sends channel c to IDLE, sets countdown to 0 and suppresses done on that edge.
  - Abort wins over both start and expiry on the same channel in the same cycle.
  - Abort on an IDLE channel has no effect.
- Independence: channels never interact. Simultaneous expiries assert multiple done bits on the same edge. A start to one channel and expiry or abort of another channel in the same cycle are both honoured.
- Derived outputs: busy = ~&inactive; any_done = |done.
- Wrap-around: load = 2^WIDTH-1 is legal and gives done after exactly 2^WIDTH-1 cycles. The counter never underflows because countdown 0 is never decremented.

Test Plan:
1. Reset, then start ch0 with load=1 at edge k → done[0] high only between edges k+1 and k+2; inactive[0] low only for edge k; remaining is 0 afterwards.
2. Start ch1 with load=16, one-shot, at edge k → done[1] at edge k+16; with mon_ch=1, remaining reads 15 after edge k+1; busy=1 from edge k to edge k+16.
3. Start ch2 with load=3, periodic=1, at edge k → done[2] pulses at k+3, k+6, k+9; abort[2] asserted at edge k+10 → no further pulses, inactive[2]=1.
4. Start ch0 with load=16 at edge k; restart ch0 with load=4 at edge k+15, and separately at edge k+16 → done only at k+19 or k+20 respectively, never at k+16.
5. Start ch0 with load=5 and ch3 with load=5 on consecutive edges, then re-time so both expire together → done=4'b1001 on one edge and any_done=1; abort with start on the same channel → no start.
6. Start ch1 with load=10; assert rst asynchronously mid-cycle at count 4 → outputs go to reset values immediately and no done ever appears; start with load=0 → behaves as abort.

Source files
------------

// File: rtl/multi_delay_timer.sv
// multi_delay_timer: a bank of independent countdown timers that share one load port.
// Each channel runs one-shot or periodic, can be retriggered or aborted, and
// pulses its done bit for one cycle on expiry.
module multi_delay_timer #(
    parameter  int WIDTH    = 12,
    parameter  int CHANNELS = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [WIDTH-1:0]    load,
    input  logic                periodic,
    input  logic [CHANNELS-1:0] abort,
    input  logic [CH_W-1:0]     mon_ch,
    output logic [CHANNELS-1:0] done,
    output logic [CHANNELS-1:0] inactive,
    output logic                any_done,
    output logic                busy,
    output logic [WIDTH-1:0]    remaining
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] COUNTING = 1'b1;

    logic [0:0]          mode      [CHANNELS];
    logic [WIDTH-1:0]    countdown [CHANNELS];
    logic [WIDTH-1:0]    reload    [CHANNELS];
    logic [CHANNELS-1:0] per;
    logic [CHANNELS-1:0] hit;

    // Decode which channel, if any, the shared load port addresses this cycle;
    // an out-of-range load_ch matches no channel and is thereby ignored.
    always_comb begin
        hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = start && (load_ch == CH_W'(i));
        end
    end

    // Per-channel state update: abort (or a zero-length start) beats a start,
    // and a start beats the expiry of the run it replaces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                mode[i]      <= IDLE;
                countdown[i] <= '0;
                reload[i]    <= '0;
            end
            per  <= '0;
            done <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                done[i] <= 1'b0;
                if (abort[i] || (hit[i] && (load == '0))) begin
                    mode[i]      <= IDLE;
                    countdown[i] <= '0;
                end else if (hit[i]) begin
                    mode[i]      <= COUNTING;
                    countdown[i] <= load;
                    reload[i]    <= load;
                    per[i]       <= periodic;
                end else if (mode[i] == COUNTING) begin
                    if (countdown[i] > WIDTH'(1)) begin
                        countdown[i] <= countdown[i] - WIDTH'(1);
                    end else begin
                        done[i] <= 1'b1;
                        if (per[i]) begin
                            countdown[i] <= reload[i];
                        end else begin
                            mode[i]      <= IDLE;
                            countdown[i] <= '0;
                        end
                    end
                end
            end
        end
    end

    // Status flags straight off the mode registers; an idle channel always
    // holds countdown 0, so the readout needs no mode qualification.
    always_comb begin
        remaining = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            inactive[i] = (mode[i] == IDLE);
            if (mon_ch == CH_W'(i)) begin
                remaining = countdown[i];
            end
        end
    end

    assign any_done = |done;
    assign busy     = ~&inactive;

endmodule

// File: tb/tb_multi_delay_timer.sv
// Testbench for multi_delay_timer: directed scenarios followed by random traffic,
// all compared against a deadline-based behavioural model.
module tb_multi_delay_timer;

    localparam int WIDTH    = 12;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

    logic                clk;
    logic                rst;
    logic                start;
    logic [CH_W-1:0]     load_ch;
    logic [WIDTH-1:0]    load;
    logic                periodic;
    logic [CHANNELS-1:0] abort;
    logic [CH_W-1:0]     mon_ch;
    logic [CHANNELS-1:0] done;
    logic [CHANNELS-1:0] inactive;
    logic                any_done;
    logic                busy;
    logic [WIDTH-1:0]    remaining;

    int errors = 0;
    int checks = 0;

    // Model: each active channel remembers the absolute cycle of its next expiry.
    longint              cyc;
    bit                  m_act    [CHANNELS];
    longint              m_dead   [CHANNELS];
    longint              m_len    [CHANNELS];
    bit                  m_per    [CHANNELS];
    logic [CHANNELS-1:0] m_done;

    multi_delay_timer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk(clk), .rst(rst), .start(start), .load_ch(load_ch), .load(load),
        .periodic(periodic), .abort(abort), .mon_ch(mon_ch), .done(done),
        .inactive(inactive), .any_done(any_done), .busy(busy), .remaining(remaining)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_act[c] = 1'b0;
            m_dead[c] = 0;
        end
        m_done = '0;
    endtask

    task automatic modelStep(input bit st, input int ch, input int ld, input bit pr,
                             input logic [CHANNELS-1:0] ab);
        cyc++;
        m_done = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ab[c] || (st && ch == c && ld == 0)) begin
                m_act[c] = 1'b0;
            end else if (st && ch == c) begin
                m_act[c]  = 1'b1;
                m_dead[c] = cyc + ld;
                m_len[c]  = ld;
                m_per[c]  = pr;
            end else if (m_act[c] && m_dead[c] == cyc) begin
                m_done[c] = 1'b1;
                if (m_per[c]) m_dead[c] = m_dead[c] + m_len[c];
                else m_act[c] = 1'b0;
            end
        end
    endtask

    task automatic checkAll();
        logic [CHANNELS-1:0] exp_inact;
        longint              exp_rem;
        for (int c = 0; c < CHANNELS; c++) exp_inact[c] = !m_act[c];
        exp_rem = m_act[int'(mon_ch)] ? (m_dead[int'(mon_ch)] - cyc) : 0;
        checkOutput("done", 32'(done), 32'(m_done));
        checkOutput("inactive", 32'(inactive), 32'(exp_inact));
        checkOutput("any_done", 32'(any_done), 32'(m_done != '0));
        checkOutput("busy", 32'(busy), 32'(exp_inact != '1));
        checkOutput("remaining", 32'(remaining), 32'(exp_rem));
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, check, return at next falling edge.
    task automatic applyStimulus(input bit st, input int ch, input int ld, input bit pr,
                                 input logic [CHANNELS-1:0] ab, input int mon);
        start    = st;
        load_ch  = CH_W'(ch);
        load     = WIDTH'(ld);
        periodic = pr;
        abort    = ab;
        mon_ch   = CH_W'(mon);
        @(posedge clk);
        modelStep(st, ch, ld, pr, ab);
        #1;
        checkAll();
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n, input int mon);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, '0, mon);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock edge.
    task automatic midReset();
        start = 1'b0;
        abort = '0;
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1;
        start = 1'b0; load_ch = '0; load = '0; periodic = 1'b0; abort = '0; mon_ch = '0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single-cycle load");
        applyStimulus(1'b1, 0, 1, 1'b0, '0, 0);
        idleCycles(3, 0);

        $display("[TB] one-shot length 16");
        applyStimulus(1'b1, 1, 16, 1'b0, '0, 1);
        idleCycles(18, 1);

        $display("[TB] periodic then abort");
        applyStimulus(1'b1, 2, 3, 1'b1, '0, 2);
        idleCycles(9, 2);
        applyStimulus(1'b0, 0, 0, 1'b0, 4'b0100, 2);
        idleCycles(6, 2);

        $display("[TB] retrigger before and at expiry");
        applyStimulus(1'b1, 0, 16, 1'b0, '0, 0);
        idleCycles(14, 0);
        applyStimulus(1'b1, 0, 4, 1'b0, '0, 0);
        idleCycles(6, 0);
        applyStimulus(1'b1, 0, 16, 1'b0, '0, 0);
        idleCycles(15, 0);
        applyStimulus(1'b1, 0, 4, 1'b0, '0, 0);
        idleCycles(6, 0);

        $display("[TB] simultaneous expiry, abort beats start");
        applyStimulus(1'b1, 0, 6, 1'b0, '0, 3);
        applyStimulus(1'b1, 3, 5, 1'b0, '0, 3);
        idleCycles(6, 3);
        applyStimulus(1'b1, 2, 7, 1'b0, 4'b0100, 2);
        idleCycles(2, 2);

        $display("[TB] async reset mid-count, zero load aborts");
        applyStimulus(1'b1, 1, 10, 1'b0, '0, 1);
        idleCycles(6, 1);
        midReset();
        idleCycles(12, 1);
        applyStimulus(1'b1, 1, 10, 1'b1, '0, 1);
        idleCycles(2, 1);
        applyStimulus(1'b1, 1, 0, 1'b0, '0, 1);
        idleCycles(12, 1);

        $display("[TB] full-scale load");
        applyStimulus(1'b1, 3, (1 << WIDTH) - 1, 1'b0, '0, 3);
        idleCycles((1 << WIDTH) + 1, 3);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            bit                  st;
            int                  ld;
            int                  sel;
            logic [CHANNELS-1:0] ab;
            st  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 15);
            if (sel == 0) ld = 0;
            else if (sel == 1) ld = $urandom_range(0, (1 << WIDTH) - 1);
            else ld = $urandom_range(1, 24);
            for (int c = 0; c < CHANNELS; c++) ab[c] = ($urandom_range(0, 40) == 0);
            applyStimulus(st, $urandom_range(0, CHANNELS - 1), ld, 1'($urandom_range(0, 1)),
                          ab, $urandom_range(0, CHANNELS - 1));
            if ($urandom_range(0, 999) == 0) midReset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
